test_monitor: RTL and testbench
===============================

# test_monitor

Synthesizable end-of-test checker that sits directly downstream of `Core`. It snoops the program counter and the register-file writeback port, keeps a shadow copy of `x3` (gp), and declares pass, fail or timeout when the riscv-tests end address is reached or the cycle budget runs out. It replaces per-test bench logic for pc/gp checking, so every rv32ui test bench instantiates one monitor and reads its sticky result flags.

## Interface
Parameters:
- `END_PC`, `32'h44`: pc value that marks test completion.
- `MAX_TICKS`, `5000`: cycle budget after reset release before timeout.

Ports:
- `clk`  in  1  system clock, rising edge active.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc`  in  32  current core pc, sampled every rising edge.
- `wb_en`  in  1  register-file write strobe.
- `wb_addr`  in  5  register-file write index.
- `wb_data`  in  32  register-file write data.
- `done`  out  1  sticky; a verdict has been reached.
- `pass`  out  1  sticky; gp==1 at END_PC.
- `fail`  out  1  sticky; gp!=1 at END_PC.
- `timeout`  out  1  sticky; MAX_TICKS elapsed without reaching END_PC.
- `fail_code`  out  32  gp value latched at verdict (failing test number = `fail_code>>1`).
- `cycle_count`  out  32  cycles spent in RUN, frozen at verdict.
- `wb_count`  out  32  register writes to x1..x31 seen in RUN (see Configuration).

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN.
- RUN:
  - Each edge with `wb_en=1 && wb_addr==3` loads `gp_shadow <= wb_data`.
  - Writes to `wb_addr==0` are ignored everywhere.
  - `cycle_count` increments by 1 per RUN edge.
- End detection: on an edge in RUN with `pc==END_PC`:
  - Effective gp = `wb_data` if this edge also writes x3 (bypass), otherwise `gp_shadow`.
  - Effective gp == 32'h1 -> PASS; any other value -> FAIL.
  - `fail_code` <= effective gp in both cases.
- Timeout: on an edge in RUN where `cycle_count == MAX_TICKS-1` and pc != END_PC -> TIMEOUT, with `fail_code <= gp_shadow`.
  - Same-edge END_PC and budget exhaustion: END_PC wins.
- PASS, FAIL and TIMEOUT are terminal until reset. All counters and `gp_shadow` freeze.
- Output decode:
  - `done` = state != RUN.
  - `pass`, `fail`, `timeout` each one-hot from state.
- `cycle_count` saturates at 32'hFFFF_FFFF. This is only reachable with MAX_TICKS=0, which disables timeout.

## Timing
- Reset values: state RUN; `done`, `pass`, `fail`, `timeout` = 0; `fail_code`, `cycle_count`, `wb_count`, `gp_shadow` = 0.
- Reset is asynchronous. Asserting `rst` mid-run or after a verdict clears everything immediately, without waiting for a clock edge.
- The first counted cycle is the first rising edge with `rst` low.
- All outputs are registered. The verdict is visible one cycle after the edge on which `pc==END_PC` is sampled, and `cycle_count` then holds the count including that edge.
- Example: pc reaches END_PC on the 10th post-reset edge -> `done=1` after that edge with `cycle_count=10`.
- No handshake. `pc` and `wb_*` are sampled unconditionally every edge.

## Configuration
- Macro `TEST_MONITOR_WBCOUNT_EN`.
- Defined: `wb_count` increments on every RUN edge with `wb_en=1 && wb_addr!=0`. It freezes at verdict and wraps modulo 2^32.
- Undefined: the counter logic is compiled out and `wb_count` is tied to 32'h0. All other behaviour is identical.

## Test plan
- Reset held 3 cycles, then x3<=1 on cycle 5 and pc=32'h44 on cycle 8 -> after that edge: `pass=1`, `done=1`, `fail_code=1`, `cycle_count=8`; flags stay set through 20 further cycles.
- x3<=32'h7 on cycle 4 (test 3 failed), pc=32'h44 on cycle 6 -> `fail=1`, `fail_code=7`, `pass=0`.
- Same-edge bypass: gp_shadow=5, then on one edge `wb_en=1`, `wb_addr=3`, `wb_data=1` and pc=32'h44 -> `pass=1`. Writes to x0 with data 1 leave gp_shadow unchanged.
- MAX_TICKS=20 and pc never reaches 32'h44 -> `timeout=1` after the 20th RUN edge with `cycle_count=20`. With pc=32'h44 on exactly edge 20 -> `pass` or `fail` is set, not `timeout`.
- Assert `rst` asynchronously between edges while `pass=1` -> all outputs read 0 before the next edge; the monitor restarts and reaches a fresh verdict.
- With `TEST_MONITOR_WBCOUNT_EN`: 6 writes to x1..x5 plus 2 to x0 before END_PC -> `wb_count=6`. Without the macro -> `wb_count=0`.

Source files
------------

// File: rtl/test_monitor_if.sv
// Bus between the core snoop points and test_monitor: pc and register-file
// writeback sampled by the monitor, sticky verdict flags and counters
// returned to the bench.
interface test_monitor_if;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] fail_code;
    logic [31:0] cycle_count;
    logic [31:0] wb_count;

    // Core/bench side: drives the snooped signals, reads the verdict.
    modport master (
        output pc, wb_en, wb_addr, wb_data,
        input  done, pass, fail, timeout, fail_code, cycle_count, wb_count
    );

    // Monitor side.
    modport slave (
        input  pc, wb_en, wb_addr, wb_data,
        output done, pass, fail, timeout, fail_code, cycle_count, wb_count
    );
endinterface

// File: rtl/test_monitor.sv
// test_monitor: end-of-test checker for riscv-tests style programs.
// Shadows x3 (gp) from the writeback port and declares pass/fail when pc
// reaches END_PC, or timeout once MAX_TICKS run cycles have elapsed.
// MAX_TICKS=0 disables the timeout.
// Optional feature: define TEST_MONITOR_WBCOUNT_EN to count writes to
// x1..x31; otherwise wb_count is tied to zero.
module test_monitor #(
    parameter logic [31:0] END_PC    = 32'h44,
    parameter int unsigned MAX_TICKS = 5000
) (
    input logic          clk,
    input logic          rst,
    test_monitor_if.slave mon
);

    localparam bit          TIMEOUT_EN = (MAX_TICKS != 0);
    localparam logic [31:0] LAST_TICK  = 32'(MAX_TICKS - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    state_t      state, state_nx;
    logic [31:0] gp_shadow;
    logic [31:0] cycle_count_q;
    logic [31:0] fail_code_q;
    logic [31:0] wb_count_q;

    logic        running;
    logic        gp_write;
    logic        at_end;
    logic        budget_out;
    logic [31:0] eff_gp;

    assign running    = (state == ST_RUN);
    assign gp_write   = mon.wb_en && (mon.wb_addr == 5'd3);
    assign at_end     = (mon.pc == END_PC);
    assign budget_out = TIMEOUT_EN && (cycle_count_q == LAST_TICK);
    // A gp write landing on the END_PC edge must count toward the verdict.
    assign eff_gp     = gp_write ? mon.wb_data : gp_shadow;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nx;
    end

    // Next-state: END_PC takes priority over budget exhaustion; verdicts are terminal.
    always_comb begin
        state_nx = state;
        if (state == ST_RUN) begin
            if (at_end)          state_nx = (eff_gp == 32'h1) ? ST_PASS : ST_FAIL;
            else if (budget_out) state_nx = ST_TIMEOUT;
        end
    end

    // Output decode from the state register, so flags change only on edges or reset.
    always_comb begin
        mon.done    = (state != ST_RUN);
        mon.pass    = (state == ST_PASS);
        mon.fail    = (state == ST_FAIL);
        mon.timeout = (state == ST_TIMEOUT);
    end

    // gp shadow, run-cycle counter and verdict code; all frozen outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gp_shadow     <= '0;
            cycle_count_q <= '0;
            fail_code_q   <= '0;
        end else if (running) begin
            if (gp_write)
                gp_shadow <= mon.wb_data;
            if (cycle_count_q != '1)
                cycle_count_q <= cycle_count_q + 32'd1;
            if (at_end)
                fail_code_q <= eff_gp;
            else if (budget_out)
                fail_code_q <= gp_shadow;
        end
    end

`ifdef TEST_MONITOR_WBCOUNT_EN
    // Count writes to architectural registers x1..x31 while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wb_count_q <= '0;
        else if (running && mon.wb_en && (mon.wb_addr != 5'd0))
            wb_count_q <= wb_count_q + 32'd1;
    end
`else
    assign wb_count_q = '0;
`endif

    assign mon.fail_code   = fail_code_q;
    assign mon.cycle_count = cycle_count_q;
    assign mon.wb_count    = wb_count_q;

endmodule

// File: tb/tb_test_monitor.sv
// Self-checking bench for test_monitor (MAX_TICKS overridden to 20).
// Directed table scenarios, hand sequences for persistence, async reset and
// wb_count, then random traces checked against a trace-level reference.
module tb_test_monitor;

    localparam logic [31:0] END_PC  = 32'h44;
    localparam int          MAXT    = 20;
    localparam int          TMAX    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    test_monitor_if bus ();

    test_monitor #(.END_PC(END_PC), .MAX_TICKS(MAXT)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Stimulus trace, indexed by post-reset edge number 1..n.
    logic [31:0] t_pc   [TMAX];
    logic        t_en   [TMAX];
    logic [4:0]  t_addr [TMAX];
    logic [31:0] t_data [TMAX];

    // Reference expectations.
    logic        e_done, e_pass, e_fail, e_to;
    logic [31:0] e_code, e_count, e_wb;

    typedef struct {
        int          w1_at;
        logic [4:0]  w1_addr;
        logic [31:0] w1_data;
        int          w2_at;
        logic [4:0]  w2_addr;
        logic [31:0] w2_data;
        int          end_at;
        int          n;
        logic        x_pass;
        logic        x_fail;
        logic        x_to;
        logic [31:0] x_code;
        logic [31:0] x_count;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.pc = 32'h0; bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'h0;
    endtask

    task automatic clear_trace();
        for (int i = 0; i < TMAX; i++) begin
            t_pc[i] = 32'h100 + 32'(4 * i); t_en[i] = 1'b0; t_addr[i] = 5'd0; t_data[i] = 32'h0;
        end
    endtask

    // Reset held three cycles, released on a falling edge; then edges 1..n.
    task automatic run_trace(input int n);
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= n; k++) begin
            bus.pc = t_pc[k]; bus.wb_en = t_en[k]; bus.wb_addr = t_addr[k]; bus.wb_data = t_data[k];
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // Reference: the run stops at the first END_PC edge, else at edge MAXT.
    // gp is the last x3 write seen up to the stop (the END_PC edge itself
    // included, the timeout edge excluded).
    task automatic model(input int n);
        int stop = 0;
        bit is_end = 0;
        logic [31:0] gp = 32'h0;
        int wbc = 0;
        for (int i = 1; i <= n; i++) begin
            if (t_pc[i] == END_PC) begin stop = i; is_end = 1; break; end
            if (i == MAXT) begin stop = i; break; end
        end
        e_done = (stop != 0);
        e_count = e_done ? 32'(stop) : 32'(n);
        for (int i = 1; i <= int'(e_count); i++) begin
            if (t_en[i] && t_addr[i] == 5'd3 && (is_end || !e_done || i < stop)) gp = t_data[i];
            if (t_en[i] && t_addr[i] != 5'd0) wbc++;
        end
        e_pass = e_done && is_end && gp == 32'h1;
        e_fail = e_done && is_end && gp != 32'h1;
        e_to   = e_done && !is_end;
        e_code = e_done ? gp : 32'h0;
`ifdef TEST_MONITOR_WBCOUNT_EN
        e_wb = 32'(wbc);
`else
        e_wb = 32'h0;
`endif
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".done"},    {31'h0, bus.done},    {31'h0, e_done});
        chk({tag, ".pass"},    {31'h0, bus.pass},    {31'h0, e_pass});
        chk({tag, ".fail"},    {31'h0, bus.fail},    {31'h0, e_fail});
        chk({tag, ".timeout"}, {31'h0, bus.timeout}, {31'h0, e_to});
        chk({tag, ".code"},    bus.fail_code,        e_code);
        chk({tag, ".count"},   bus.cycle_count,      e_count);
        chk({tag, ".wb"},      bus.wb_count,         e_wb);
    endtask

    vec_t vecs [8];

    initial begin
        idle_inputs();
        // {w1_at,addr,data, w2_at,addr,data, end_at, n, pass,fail,to, code, count}
        vecs[0] = '{5, 5'd3, 32'h1,  0, 5'd0, 32'h0,  8,  8, 1,0,0, 32'h1, 32'd8};
        vecs[1] = '{4, 5'd3, 32'h7,  0, 5'd0, 32'h0,  6,  6, 0,1,0, 32'h7, 32'd6};
        vecs[2] = '{2, 5'd3, 32'h5,  9, 5'd3, 32'h1,  9,  9, 1,0,0, 32'h1, 32'd9};
        vecs[3] = '{2, 5'd3, 32'h5,  4, 5'd0, 32'h1,  7,  7, 0,1,0, 32'h5, 32'd7};
        vecs[4] = '{3, 5'd3, 32'h1,  0, 5'd0, 32'h0, 20, 20, 1,0,0, 32'h1, 32'd20};
        vecs[5] = '{5, 5'd3, 32'h3, 20, 5'd3, 32'h9,  0, 22, 0,0,1, 32'h3, 32'd20};
        vecs[6] = '{5, 5'd3, 32'h3, 19, 5'd3, 32'h9, 21, 24, 0,0,1, 32'h9, 32'd20};
        vecs[7] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1,  1, 0,1,0, 32'h0, 32'd1};

        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        e_done = 0; e_pass = 0; e_fail = 0; e_to = 0; e_code = 0; e_count = 0; e_wb = 0;
        chk_all("reset");

        for (int v = 0; v < 8; v++) begin
            clear_trace();
            if (vecs[v].w1_at != 0) begin
                t_en[vecs[v].w1_at] = 1'b1; t_addr[vecs[v].w1_at] = vecs[v].w1_addr; t_data[vecs[v].w1_at] = vecs[v].w1_data;
            end
            if (vecs[v].w2_at != 0) begin
                t_en[vecs[v].w2_at] = 1'b1; t_addr[vecs[v].w2_at] = vecs[v].w2_addr; t_data[vecs[v].w2_at] = vecs[v].w2_data;
            end
            if (vecs[v].end_at != 0) t_pc[vecs[v].end_at] = END_PC;
            run_trace(vecs[v].n);
            model(vecs[v].n);
            e_done = 1'b1; e_pass = vecs[v].x_pass; e_fail = vecs[v].x_fail; e_to = vecs[v].x_to;
            e_code = vecs[v].x_code; e_count = vecs[v].x_count;
            chk_all($sformatf("vec%0d", v));

            if (v == 0) begin
                // Flags and counters stay frozen through 20 more cycles of activity.
                for (int k = 0; k < 20; k++) begin
                    bus.pc = END_PC; bus.wb_en = 1'b1; bus.wb_addr = 5'(1 + k % 4); bus.wb_data = 32'h99;
                    @(negedge clk);
                end
                idle_inputs();
                chk_all("sticky");

                // Async reset mid-cycle while pass=1: outputs clear before any edge.
                #2 rst = 1'b1;
                #1;
                e_done = 0; e_pass = 0; e_fail = 0; e_to = 0; e_code = 0; e_count = 0; e_wb = 0;
                chk_all("async_rst");
                @(negedge clk);
                rst = 1'b0;
            end
        end

        // wb_count: six writes to x1..x5, two to x0, END_PC at edge 12.
        clear_trace();
        for (int k = 1; k <= 6; k++) begin
            t_en[k] = 1'b1; t_addr[k] = 5'(k <= 5 ? k : 1); t_data[k] = (k == 3) ? 32'h1 : 32'h55;
        end
        t_en[7] = 1'b1; t_data[7] = 32'h1;
        t_en[8] = 1'b1; t_data[8] = 32'h2;
        t_pc[12] = END_PC;
        run_trace(12);
`ifdef TEST_MONITOR_WBCOUNT_EN
        chk("wbcount", bus.wb_count, 32'd6);
`else
        chk("wbcount", bus.wb_count, 32'd0);
`endif
        chk("wbcount.pass", {31'h0, bus.pass}, 32'h1);

        // Random traces against the reference.
        for (int r = 0; r < 40; r++) begin
            int n = int'($urandom_range(1, 30));
            for (int k = 1; k <= n; k++) begin
                logic [31:0] p = $urandom & 32'hFFFC;
                if (p == END_PC) p = 32'h48;
                t_pc[k]   = ($urandom_range(0, 24) == 0) ? END_PC : p;
                t_en[k]   = $urandom_range(0, 1) == 1;
                t_addr[k] = ($urandom_range(0, 2) == 0) ? 5'd3 : 5'($urandom_range(0, 7));
                t_data[k] = ($urandom_range(0, 1) == 1) ? 32'h1 : 32'($urandom_range(0, 15));
            end
            run_trace(n);
            model(n);
            chk_all($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
        $fatal(1);
    end

endmodule
